// File: rtl/fpnew_slice_out_arbiter_if.sv
// Slice-to-output arbiter bus: per-slice result lanes in, one ordered stream out.
// Ports: slave = arbiter side, master = slice/downstream side.
interface fpnew_slice_out_arbiter_if #(
  parameter int NumSlices = 4,
  parameter int Width     = 32,
  parameter int TagWidth  = 1
);
  localparam int SrcW = $clog2(NumSlices);

  logic [NumSlices*Width-1:0]    slice_result_i;
  logic [NumSlices*5-1:0]        slice_status_i;
  logic [NumSlices-1:0]          slice_ext_bit_i;
  logic [NumSlices*TagWidth-1:0] slice_tag_i;
  logic [NumSlices-1:0]          slice_valid_i;
  logic [NumSlices-1:0]          slice_ready_o;
  logic                          flush_i;
  logic [Width-1:0]              result_o;
  logic [4:0]                    status_o;
  logic                          extension_bit_o;
  logic [TagWidth-1:0]           tag_o;
  logic [SrcW-1:0]               src_o;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic                          busy_o;

  modport slave (
    input  slice_result_i,
    input  slice_status_i,
    input  slice_ext_bit_i,
    input  slice_tag_i,
    input  slice_valid_i,
    output slice_ready_o,
    input  flush_i,
    output result_o,
    output status_o,
    output extension_bit_o,
    output tag_o,
    output src_o,
    output out_valid_o,
    input  out_ready_i,
    output busy_o
  );

  modport master (
    output slice_result_i,
    output slice_status_i,
    output slice_ext_bit_i,
    output slice_tag_i,
    output slice_valid_i,
    input  slice_ready_o,
    output flush_i,
    input  result_o,
    input  status_o,
    input  extension_bit_o,
    input  tag_o,
    input  src_o,
    input  out_valid_o,
    output out_ready_i,
    input  busy_o
  );
endinterface

// File: rtl/fpnew_slice_out_arbiter.sv
// Round-robin arbiter merging per-slice results into one in-order output FIFO.
// Ports: clk_i, rst_i (async, active-high), bus (slave modport of the _if).
module fpnew_slice_out_arbiter #(
  parameter int NumSlices = 4,
  parameter int Width     = 32,
  parameter int TagWidth  = 1,
  parameter int FifoDepth = 2
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  fpnew_slice_out_arbiter_if.slave     bus
);
  localparam int SrcW = $clog2(NumSlices);
  localparam int PtrW = $clog2(FifoDepth);
  localparam int CntW = $clog2(FifoDepth + 1);
  localparam logic [CntW-1:0] Full = CntW'(FifoDepth);
  localparam logic [SrcW:0]   NSl  = (SrcW+1)'(NumSlices);

  logic [Width-1:0]    r_res [FifoDepth];
  logic [4:0]          r_st  [FifoDepth];
  logic                r_ext [FifoDepth];
  logic [TagWidth-1:0] r_tag [FifoDepth];
  logic [SrcW-1:0]     r_src [FifoDepth];

  logic [PtrW-1:0] r_wr;
  logic [PtrW-1:0] r_rd;
  logic [CntW-1:0] r_cnt;
  logic [SrcW-1:0] r_rr;

  logic [2*NumSlices-1:0] w_dbl;
  logic                   w_found;
  logic [SrcW-1:0]        w_off;
  logic [SrcW:0]          w_sum;
  logic [SrcW-1:0]        w_win;
  logic                   w_valid;
  logic                   w_pop;
  logic                   w_space;
  logic                   w_push;
  logic [NumSlices-1:0]   w_ready;
  logic [Width-1:0]       w_res;
  logic [4:0]             w_st;
  logic                   w_ext;
  logic [TagWidth-1:0]    w_tag;

  // Rotate valids so the search always starts at r_rr,
  // then map the offset back to an absolute slice index.
  always_comb begin
    w_dbl   = {bus.slice_valid_i, bus.slice_valid_i} >> r_rr;
    w_found = 1'b0;
    w_off   = '0;
    for (int i = 0; i < NumSlices; i++) begin
      if (!w_found && w_dbl[i]) begin
        w_found = 1'b1;
        w_off   = SrcW'(i);
      end
    end
    w_sum = {1'b0, r_rr} + {1'b0, w_off};
    if (w_sum >= NSl) begin
      w_sum = w_sum - NSl;
    end
    w_win = w_sum[SrcW-1:0];
  end

  assign w_valid = (r_cnt != '0);
  assign w_pop   = w_valid & bus.out_ready_i;
  assign w_space = (r_cnt < Full) | w_pop;
  assign w_push  = w_found & w_space & ~bus.flush_i & ~rst_i;

  always_comb begin
    w_res = bus.slice_result_i[int'(w_win)*Width +: Width];
    w_st  = bus.slice_status_i[int'(w_win)*5 +: 5];
    w_ext = bus.slice_ext_bit_i[w_win];
    w_tag = bus.slice_tag_i[int'(w_win)*TagWidth +: TagWidth];
  end

  // Flush drains every slice; the drained data is simply dropped.
  always_comb begin
    w_ready = '0;
    if (rst_i) begin
      w_ready = '0;
    end else if (bus.flush_i) begin
      w_ready = '1;
    end else if (w_push) begin
      w_ready[w_win] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
      r_rr  <= '0;
    end else if (bus.flush_i) begin
      r_cnt <= '0;
      r_wr  <= '0;
      r_rd  <= '0;
    end else begin
      if (w_push) begin
        r_wr <= r_wr + 1'b1;
        r_rr <= (w_win == SrcW'(NumSlices - 1)) ?
                '0 : w_win + 1'b1;
      end
      if (w_pop) begin
        r_rd <= r_rd + 1'b1;
      end
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  // Payload storage needs no reset: the count gates its visibility.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_res[r_wr] <= w_res;
      r_st[r_wr]  <= w_st;
      r_ext[r_wr] <= w_ext;
      r_tag[r_wr] <= w_tag;
      r_src[r_wr] <= w_win;
    end
  end

  // Empty (including reset, which clears the count at once)
  // presents zeros instead of stale storage.
  assign bus.result_o        = w_valid ? r_res[r_rd] : '0;
  assign bus.status_o        = w_valid ? r_st[r_rd]  : '0;
  assign bus.extension_bit_o = w_valid ? r_ext[r_rd] : 1'b0;
  assign bus.tag_o           = w_valid ? r_tag[r_rd] : '0;
  assign bus.src_o           = w_valid ? r_src[r_rd] : '0;
  assign bus.out_valid_o     = w_valid;
  assign bus.slice_ready_o   = w_ready;
  assign bus.busy_o          = w_valid | (|bus.slice_valid_i);
endmodule
